// File: rtl/pdm_pkg.sv
// rtl/pdm_pkg.sv - shared constants and elaboration helpers for the PDM receive path
package pdm_pkg;

  localparam real DEF_CLK_FREQ  = 100.0;
  localparam real DEF_MCLK_FREQ = 2.5;

  function automatic int pdm_half(input real clk_f, input real mclk_f);
    return $rtoi(clk_f / (2.0 * mclk_f));
  endfunction

  // The divider only produces an exact mic clock for an integral half period of at least 2.
  function automatic bit pdm_half_ok(input real clk_f, input real mclk_f);
    real h;
    h = clk_f / (2.0 * mclk_f);
    return (h >= 2.0) && (h == $itor($rtoi(h)));
  endfunction

  function automatic int pdm_aw(input int sample_count);
    return $clog2(sample_count);
  endfunction

endpackage

// File: rtl/pdm_window_acc.sv
// rtl/pdm_window_acc.sv - ones counter over one decimation window, cleared when its window closes
module pdm_window_acc #(
  parameter int AW = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_en,
  input  logic        bit_in,
  input  logic        close,
  output logic [AW:0] total
);

  logic [AW:0] acc_q;

  // total includes the bit arriving with the closing sample, so the window is complete.
  assign total = acc_q + {{AW{1'b0}}, bit_in};

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else if (close) begin
      acc_q <= '0;
    end else if (sample_en) begin
      acc_q <= total;
    end
  end

endmodule

// File: rtl/pdm_input.sv
// rtl/pdm_input.sv - PDM mic clock generation, sampling and half-window overlapped decimation
module pdm_input
  import pdm_pkg::*;
#(
  parameter real CLK_FREQ     = DEF_CLK_FREQ,
  parameter real MCLK_FREQ    = DEF_MCLK_FREQ,
  parameter int  SAMPLE_COUNT = 128,
  localparam int AW           = pdm_aw(SAMPLE_COUNT)
) (
  input  logic          clk,
  input  logic          reset,
  output logic          m_clk,
  input  logic          m_data,
  output logic [AW-1:0] amplitude,
  output logic          amplitude_valid
);

  localparam int HALF = pdm_half(CLK_FREQ, MCLK_FREQ);
  localparam int CW   = (HALF > 2) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HALF - 1);
  localparam logic [AW-1:0] CLOSE0   = AW'(SAMPLE_COUNT - 1);
  localparam logic [AW-1:0] CLOSE1   = AW'(SAMPLE_COUNT / 2 - 1);

  if (!pdm_half_ok(CLK_FREQ, MCLK_FREQ)) begin : g_bad_half
    $error("pdm_input: CLK_FREQ/(2*MCLK_FREQ) must be an integer >= 2");
  end
  if (SAMPLE_COUNT < 4 || SAMPLE_COUNT > 1024 ||
      (SAMPLE_COUNT & (SAMPLE_COUNT - 1)) != 0) begin : g_bad_count
    $error("pdm_input: SAMPLE_COUNT must be a power of two in 4..1024");
  end

  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic          m_clk_q, m_clk_d;
  logic [AW-1:0] sample_cnt_q, sample_cnt_d;
  logic          first_q, first_d;
  logic [AW-1:0] amp_q, amp_d;
  logic          valid_q, valid_d;

  logic          wrap, rise, close0, close1;
  logic [AW:0]   total0, total1;

  function automatic logic [AW-1:0] saturate(input logic [AW:0] t);
    return t[AW] ? {AW{1'b1}} : t[AW-1:0];
  endfunction

  assign wrap   = (clk_cnt_q == CNT_LAST);
  assign rise   = wrap && !m_clk_q;
  assign close0 = rise && (sample_cnt_q == CLOSE0);
  assign close1 = rise && (sample_cnt_q == CLOSE1);

  // Two windows offset by half a window give one output every SAMPLE_COUNT/2 samples.
  pdm_window_acc #(.AW(AW)) u_acc0 (
    .clk       (clk),
    .reset     (reset),
    .sample_en (rise),
    .bit_in    (m_data),
    .close     (close0),
    .total     (total0)
  );

  pdm_window_acc #(.AW(AW)) u_acc1 (
    .clk       (clk),
    .reset     (reset),
    .sample_en (rise),
    .bit_in    (m_data),
    .close     (close1),
    .total     (total1)
  );

  always_comb begin
    clk_cnt_d    = wrap ? '0 : clk_cnt_q + 1'b1;
    m_clk_d      = m_clk_q ^ wrap;
    sample_cnt_d = rise ? sample_cnt_q + 1'b1 : sample_cnt_q;
    first_d      = first_q;
    amp_d        = amp_q;
    valid_d      = 1'b0;
    if (close0) begin
      amp_d   = saturate(total0);
      valid_d = 1'b1;
    end else if (close1) begin
      // acc1's first window after reset is only half full, so it is dropped.
      if (first_q) begin
        first_d = 1'b0;
      end else begin
        amp_d   = saturate(total1);
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_cnt_q    <= '0;
      m_clk_q      <= 1'b0;
      sample_cnt_q <= '0;
      first_q      <= 1'b1;
      amp_q        <= '0;
      valid_q      <= 1'b0;
    end else begin
      clk_cnt_q    <= clk_cnt_d;
      m_clk_q      <= m_clk_d;
      sample_cnt_q <= sample_cnt_d;
      first_q      <= first_d;
      amp_q        <= amp_d;
      valid_q      <= valid_d;
    end
  end

  assign m_clk           = m_clk_q;
  assign amplitude       = amp_q;
  assign amplitude_valid = valid_q;

endmodule
